// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller between a one-cycle-latency
// synchronous instruction memory and the decode stage. Owns the PC, issues one
// word per cycle, parks an in-flight response in a one-entry skid buffer while
// the hazard unit stalls, redirects on taken branches and stops on HALT (32'h0).
// Optional build macro: FETCH_PERF_CNT_EN enables the two performance counters;
// without it o_perf_fetched / o_perf_stalls are tied to zero.
module fetch_sequencer #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int START_ADDR = 0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_inst,
    output logic [DATA_W-1:0] o_inst_out,
    output logic [ADDR_W-1:0] o_pc_out,
    output logic              o_inst_valid,
    output logic              o_halted,
    output logic [31:0]       o_perf_fetched,
    output logic [31:0]       o_perf_stalls
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;

    // stage 1: fetch issued last cycle, its word is on i_mem_inst now
    logic                r_pend_vld_p1;
    logic [ADDR_W-1:0]   r_pend_pc_p1;

    // skid entry: a stage-1 response caught while the output was frozen
    logic                r_skid_vld;
    logic [DATA_W-1:0]   r_skid_inst;
    logic [ADDR_W-1:0]   r_skid_pc;

    // stage 2: word presented to decode
    logic                r_vld_p2;
    logic [DATA_W-1:0]   r_inst_p2;
    logic [ADDR_W-1:0]   r_pc_p2;
    logic                r_halted;

    logic                w_cand_vld;
    logic [DATA_W-1:0]   w_cand_inst;
    logic [ADDR_W-1:0]   w_cand_pc;
    logic                w_issue;
    logic                w_load;
    logic                w_halt_load;
    logic [ADDR_W-1:0]   w_mem_addr;

    // The skid word is older than the stage-1 response, so it always goes first.
    assign w_cand_vld  = r_skid_vld | r_pend_vld_p1;
    assign w_cand_inst = r_skid_vld ? r_skid_inst : i_mem_inst;
    assign w_cand_pc   = r_skid_vld ? r_skid_pc   : r_pend_pc_p1;

    // Next state, issue decision, memory address and output-load decision
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        w_halt_load = 1'b0;
        w_mem_addr  = r_pc;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!i_stall && !i_branch_taken) begin
                    w_load      = w_cand_vld;
                    w_halt_load = w_cand_vld && (w_cand_inst == '0);
                end
                // nothing is fetched past a HALT word
                if (!i_stall && !w_halt_load) begin
                    w_issue    = 1'b1;
                    w_mem_addr = i_branch_taken ? i_branch_target : r_pc;
                end
                if (w_halt_load) w_state_nxt = S_HALTED;
            end
            S_HALTED: ;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State, PC, stage-1 pending fetch, skid entry and stage-2 output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_pc          <= START_PC;
            r_pend_vld_p1 <= 1'b0;
            r_skid_vld    <= 1'b0;
            r_vld_p2      <= 1'b0;
            r_inst_p2     <= '0;
            r_pc_p2       <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (i_start) r_pc <= START_PC;
                end
                S_RUN: begin
                    if (i_branch_taken) begin
                        // squash everything in flight; refetch from the target
                        r_skid_vld    <= 1'b0;
                        r_vld_p2      <= 1'b0;
                        r_pend_vld_p1 <= w_issue;
                        r_pend_pc_p1  <= i_branch_target;
                        r_pc          <= i_stall ? i_branch_target : pc_inc(i_branch_target);
                    end else if (i_stall) begin
                        r_pend_vld_p1 <= 1'b0;
                        if (r_pend_vld_p1) begin
                            r_skid_vld  <= 1'b1;
                            r_skid_inst <= i_mem_inst;
                            r_skid_pc   <= r_pend_pc_p1;
                        end
                    end else begin
                        r_pend_vld_p1 <= w_issue;
                        r_pend_pc_p1  <= r_pc;
                        if (w_issue) r_pc <= pc_inc(r_pc);
                        r_vld_p2 <= w_load;
                        if (w_load) begin
                            r_inst_p2 <= w_cand_inst;
                            r_pc_p2   <= w_cand_pc;
                        end
                        // a skid word leaving while stage 1 is also live hands the slot over
                        if (r_skid_vld && r_pend_vld_p1 && !w_halt_load) begin
                            r_skid_inst <= i_mem_inst;
                            r_skid_pc   <= r_pend_pc_p1;
                        end else begin
                            r_skid_vld <= 1'b0;
                        end
                        if (w_halt_load) r_halted <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (!i_stall) r_vld_p2 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_mem_addr   = w_mem_addr;
    assign o_inst_out   = r_inst_p2;
    assign o_pc_out     = r_pc_p2;
    assign o_inst_valid = r_vld_p2;
    assign o_halted     = r_halted;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stalls;

    // Delivered-word and RUN-stall-cycle counters, free-running and wrapping
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_perf_fetched <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (w_load) r_perf_fetched <= r_perf_fetched + 32'd1;
            if ((r_state == S_RUN) && i_stall) r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_stalls  = r_perf_stalls;
`else
    assign o_perf_fetched = '0;
    assign o_perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: the model predicts the stream of (pc, word) pairs
// decode must see -- sequential from the start address, restarted at each branch
// target, ending after the first all-zero word -- and queues it; a separate
// monitor pops one entry for every fresh word the DUT presents.
module tb_fetch_sequencer;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int SA    = 0;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, stall, br;
    logic [AW-1:0] tgt;
    logic [AW-1:0] mem_addr, pc_out;
    logic [DW-1:0] mem_inst, inst_out;
    logic          inst_valid, halted;
    logic [31:0]   perf_fetched, perf_stalls;
    logic [DW-1:0] mem [DEPTH];

    exp_t exp_q[$];
    int   mstate  = 0;   // 0 idle, 1 run, 2 halted
    int   mstalls = 0;
    int   n_deliv = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;
    bit   mon_halted = 1'b0;
    bit   e_rst, e_stall, e_br, e_run, e_idle, exp_valid;

    fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(SA)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_start         (start),
        .i_stall         (stall),
        .i_branch_taken  (br),
        .i_branch_target (tgt),
        .o_mem_addr      (mem_addr),
        .i_mem_inst      (mem_inst),
        .o_inst_out      (inst_out),
        .o_pc_out        (pc_out),
        .o_inst_valid    (inst_valid),
        .o_halted        (halted),
        .o_perf_fetched  (perf_fetched),
        .o_perf_stalls   (perf_stalls)
    );

    always #5 clk = ~clk;

    // synchronous-read instruction memory, one cycle latency
    always @(posedge clk) mem_inst <= mem[mem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    endtask

    task automatic push_seq(input logic [AW-1:0] from);
        logic [AW-1:0] a;
        a = from;
        for (int k = 0; k < DEPTH; k++) begin
            exp_q.push_back('{pc: a, inst: mem[a]});
            if (mem[a] == '0) break;
            a = a + 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit st, input bit b, input logic [AW-1:0] t);
        rst = r; start = s; stall = st; br = b; tgt = t;
        @(posedge clk);
        #1;
    endtask

    // reference model: reacts to the inputs sampled at each rising edge
    initial begin
        bit p_ok;
        forever begin
            @(posedge clk);
            if (mstate == 1 && mon_halted) mstate = 2;
            p_ok      = e_run && !e_stall;
            e_rst     = rst;
            e_stall   = stall;
            e_run     = (mstate == 1) && !rst;
            e_br      = br && e_run;
            exp_valid = p_ok && e_run && !stall && !br;
            if (rst) begin
                mstate  = 0;
                mstalls = 0;
                exp_q.delete();
            end else if (mstate == 0) begin
                if (start) begin
                    mstate = 1;
                    push_seq(AW'(SA));
                end
            end else if (mstate == 1) begin
                if (stall) mstalls++;
                if (br) begin
                    exp_q.delete();
                    push_seq(tgt);
                end
            end
            e_idle = (mstate == 0);
        end
    end

    // monitor: samples on the falling edge
    initial begin
        exp_t          e;
        logic [AW-1:0] halt_addr;
        bit            was_halted;
        logic          pv;
        logic [DW-1:0] pi;
        logic [AW-1:0] pp;
        halt_addr = '0; pv = 1'b0; pi = '0; pp = '0;
        forever begin
            @(negedge clk);
            if (e_rst) begin
                chk("rst_valid",    64'(inst_valid), 64'(0));
                chk("rst_halted",   64'(halted),     64'(0));
                chk("rst_inst",     64'(inst_out),   64'(0));
                chk("rst_pc",       64'(pc_out),     64'(0));
                chk("rst_mem_addr", 64'(mem_addr),   64'(SA));
                mon_halted = 1'b0;
                n_deliv    = 0;
            end else begin
                was_halted = mon_halted;
                if (e_idle) chk("idle_mem_addr", 64'(mem_addr), 64'(SA));
                if (e_br) begin
                    chk("branch_bubble", 64'(inst_valid), 64'(0));
                end else if (e_stall) begin
                    chk("stall_hold_valid", 64'(inst_valid), 64'(pv));
                    chk("stall_hold_inst",  64'(inst_out),   64'(pi));
                    chk("stall_hold_pc",    64'(pc_out),     64'(pp));
                end
                if (exp_valid) chk("throughput_valid", 64'(inst_valid), 64'(1));
                if (!e_stall && !e_br && inst_valid) begin
                    n_deliv++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_word: actual pc %0d inst %0h, required no delivery at %0t",
                                 pc_out, inst_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pc_out",   64'(pc_out),   64'(e.pc));
                        chk("inst_out", 64'(inst_out), 64'(e.inst));
                        chk("halted_on_word", 64'(halted), 64'(e.inst == '0));
                        if (e.inst == '0) begin
                            mon_halted = 1'b1;
                            halt_addr  = mem_addr;
                        end
                    end
                end
                if (was_halted) begin
                    chk("halt_mem_addr_frozen", 64'(mem_addr), 64'(halt_addr));
                    chk("halted_sticky",        64'(halted),   64'(1));
                end
            end
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetched", 64'(perf_fetched), 64'(n_deliv));
            chk("perf_stalls",  64'(perf_stalls),  64'(mstalls));
`else
            chk("perf_fetched_off", 64'(perf_fetched), 64'(0));
            chk("perf_stalls_off",  64'(perf_stalls),  64'(0));
`endif
            pv = inst_valid; pi = inst_out; pp = pc_out;
        end
    end

    // stimulus
    initial begin
        bit r, s, st, b;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
        mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd0;

        // short program ending in HALT
        repeat (3) step(1, 0, 0, 0, '0);
        step(0, 0, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        repeat (10) step(0, 0, 0, 0, '0);
        chk("halted_after_program", 64'(halted), 64'(1));
        chk("program_drained",      64'(exp_q.size()), 64'(0));

        // stall three cycles with a fetch in flight
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom();
            if (mem[i] == '0) mem[i] = 32'h1;
        end
        mem[60] = '0;
        step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        repeat (5) step(0, 0, 0, 0, '0);
        repeat (3) step(0, 0, 1, 0, '0);
        repeat (10) step(0, 0, 0, 0, '0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stalls_three", 64'(perf_stalls), 64'(3));
`endif

        // taken branch mid-stream
        step(0, 0, 0, 1, AW'(100));
        repeat (6) step(0, 0, 0, 0, '0);

        // branch while stalled discards the skid word
        repeat (2) step(0, 0, 1, 0, '0);
        step(0, 0, 1, 1, AW'(200));
        step(0, 0, 1, 0, '0);
        repeat (6) step(0, 0, 0, 0, '0);

        // PC wrap 2047 -> 0, running on to the HALT at 60
        step(0, 0, 0, 1, AW'(2044));
        repeat (80) step(0, 0, 0, 0, '0);
        chk("halted_after_wrap", 64'(halted), 64'(1));

        // reset with a full skid entry, then resume only after start
        step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        repeat (6) step(0, 0, 0, 0, '0);
        repeat (2) step(0, 0, 1, 0, '0);
        step(1, 0, 1, 0, '0);
        repeat (5) step(0, 0, 0, 0, '0);
        chk("idle_no_output", 64'(inst_valid), 64'(0));
        step(0, 1, 0, 0, '0);
        repeat (10) step(0, 0, 0, 0, '0);

        // randomized traffic
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++)
            mem[i] = ($urandom_range(0, 49) == 0) ? '0 : ($urandom() | 32'h1);
        step(1, 0, 0, 0, '0);
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 99) < 2) || (mstate == 2 && $urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 9) < 3);
            b  = ($urandom_range(0, 19) == 0);
            step(r, s, st, b, AW'($urandom()));
        end
        repeat (2) step(0, 0, 0, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
